// File: rtl/mem_req_arbiter_if.sv
// Memory controller request bus: fetch port and load/store (LSB) port.
// master = arbiter side (drives enables/fields), slave = controller side (drives done/data).
interface mem_req_arbiter_if #(
  parameter int IF_BYTES = 4
);
  logic                    mc_if_en;
  logic [31:0]             mc_if_pc;
  logic                    mc_if_done;
  logic [IF_BYTES*8-1:0]   mc_if_data;
  logic                    mc_lsb_en;
  logic                    mc_lsb_rw;
  logic [31:0]             mc_lsb_addr;
  logic [2:0]              mc_lsb_len;
  logic [31:0]             mc_lsb_w_data;
  logic                    mc_lsb_done;
  logic [31:0]             mc_lsb_r_data;

  modport master (
    output mc_if_en, mc_if_pc,
    output mc_lsb_en, mc_lsb_rw, mc_lsb_addr, mc_lsb_len, mc_lsb_w_data,
    input  mc_if_done, mc_if_data,
    input  mc_lsb_done, mc_lsb_r_data
  );

  modport slave (
    input  mc_if_en, mc_if_pc,
    input  mc_lsb_en, mc_lsb_rw, mc_lsb_addr, mc_lsb_len, mc_lsb_w_data,
    output mc_if_done, mc_if_data,
    output mc_lsb_done, mc_lsb_r_data
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbiter for fetch/load/store requesters onto a byte-serial memory controller.
// Ports: clk, rst (async, active-high), rdy, rollback; if_*/ld_*/st_* requester
// handshakes; mc = controller bus (master modport). Priority ST > LD > IF, one
// operation outstanding, one cool cycle after each completion, rollback squashes
// fetch/load. Optional fetch-aging via macro ARB_AGING_EN (parameter AGE_LIMIT).
module mem_req_arbiter #(
  parameter int IF_BYTES  = 4
`ifdef ARB_AGING_EN
  ,
  parameter int AGE_LIMIT = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [IF_BYTES*8-1:0] if_data,
  input  logic                  ld_req,
  input  logic [31:0]           ld_addr,
  input  logic [2:0]            ld_len,
  output logic                  ld_done,
  output logic [31:0]           ld_data,
  input  logic                  st_req,
  input  logic [31:0]           st_addr,
  input  logic [2:0]            st_len,
  input  logic [31:0]           st_data,
  output logic                  st_done,
  mem_req_arbiter_if.master     mc
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_LD,
    BUSY_ST,
    COOL
  } state_t;

  state_t state;
  state_t state_n;

  logic squash;
  logic force_if;
  logic gnt_if;
  logic gnt_ld;
  logic gnt_st;
  logic cpl_if;
  logic cpl_ld;
  logic cpl_st;
  logic kill;

  // A completion is dropped if its op was squashed earlier or in this cycle.
  assign kill = squash | rollback;

`ifdef ARB_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);

  logic [AW-1:0] age;

  assign force_if = (age >= AW'(AGE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (!if_req || gnt_if) begin
      age <= '0;
    end else if ((gnt_ld || gnt_st) && !force_if) begin
      age <= age + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_if  = 1'b0;
    gnt_ld  = 1'b0;
    gnt_st  = 1'b0;
    cpl_if  = 1'b0;
    cpl_ld  = 1'b0;
    cpl_st  = 1'b0;
    case (state)
      IDLE: begin
        if (rdy) begin
          if (force_if && if_req && !rollback) begin
            gnt_if = 1'b1;
          end else if (st_req) begin
            gnt_st = 1'b1;
          end else if (ld_req && !rollback) begin
            gnt_ld = 1'b1;
          end else if (if_req && !rollback) begin
            gnt_if = 1'b1;
          end
        end
        unique case (1'b1)
          gnt_if:  state_n = BUSY_IF;
          gnt_ld:  state_n = BUSY_LD;
          gnt_st:  state_n = BUSY_ST;
          default: state_n = IDLE;
        endcase
      end
      BUSY_IF: begin
        if (mc.mc_if_done) begin
          cpl_if  = 1'b1;
          state_n = COOL;
        end
      end
      BUSY_LD: begin
        if (mc.mc_lsb_done) begin
          cpl_ld  = 1'b1;
          state_n = COOL;
        end
      end
      BUSY_ST: begin
        if (mc.mc_lsb_done) begin
          cpl_st  = 1'b1;
          state_n = COOL;
        end
      end
      COOL: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Squash flag: set by rollback during a fetch/load, cleared by its completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash <= 1'b0;
    end else if (cpl_if || cpl_ld || cpl_st) begin
      squash <= 1'b0;
    end else if (rollback && (state == BUSY_IF || state == BUSY_LD)) begin
      squash <= 1'b1;
    end
  end

  // Controller fetch port: fields latched on grant, held while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc.mc_if_en <= 1'b0;
      mc.mc_if_pc <= '0;
    end else if (gnt_if) begin
      mc.mc_if_en <= 1'b1;
      mc.mc_if_pc <= if_addr;
    end else if (cpl_if) begin
      mc.mc_if_en <= 1'b0;
    end
  end

  // Controller LSB port: shared by loads and stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc.mc_lsb_en     <= 1'b0;
      mc.mc_lsb_rw     <= 1'b0;
      mc.mc_lsb_addr   <= '0;
      mc.mc_lsb_len    <= '0;
      mc.mc_lsb_w_data <= '0;
    end else if (gnt_st) begin
      mc.mc_lsb_en     <= 1'b1;
      mc.mc_lsb_rw     <= 1'b1;
      mc.mc_lsb_addr   <= st_addr;
      mc.mc_lsb_len    <= st_len;
      mc.mc_lsb_w_data <= st_data;
    end else if (gnt_ld) begin
      mc.mc_lsb_en     <= 1'b1;
      mc.mc_lsb_rw     <= 1'b0;
      mc.mc_lsb_addr   <= ld_addr;
      mc.mc_lsb_len    <= ld_len;
      mc.mc_lsb_w_data <= '0;
    end else if (cpl_ld || cpl_st) begin
      mc.mc_lsb_en     <= 1'b0;
    end
  end

  // Completion routing back to requesters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_done <= 1'b0;
      if_data <= '0;
      ld_done <= 1'b0;
      ld_data <= '0;
      st_done <= 1'b0;
    end else begin
      if_done <= 1'b0;
      ld_done <= 1'b0;
      st_done <= cpl_st;
      if (cpl_if && !kill) begin
        if_done <= 1'b1;
        if_data <= mc.mc_if_data;
      end
      if (cpl_ld && !kill) begin
        ld_done <= 1'b1;
        ld_data <= mc.mc_lsb_r_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; the bench plays the memory controller.
// Aging steps run only when built with ARB_AGING_EN.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_len;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_req;
  logic [31:0] st_addr;
  logic [2:0]  st_len;
  logic [31:0] st_data;
  logic        st_done;

  int n_cmp = 0;
  int n_bad = 0;

  mem_req_arbiter_if #(.IF_BYTES(4)) mc ();

  mem_req_arbiter #(.IF_BYTES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_data  (if_data),
    .ld_req   (ld_req),
    .ld_addr  (ld_addr),
    .ld_len   (ld_len),
    .ld_done  (ld_done),
    .ld_data  (ld_data),
    .st_req   (st_req),
    .st_addr  (st_addr),
    .st_len   (st_len),
    .st_data  (st_data),
    .st_done  (st_done),
    .mc       (mc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic if_cpl(input logic [31:0] d);
    mc.mc_if_done = 1'b1;
    mc.mc_if_data = d;
    tick();
    mc.mc_if_done = 1'b0;
  endtask

  task automatic lsb_cpl(input logic [31:0] d);
    mc.mc_lsb_done   = 1'b1;
    mc.mc_lsb_r_data = d;
    tick();
    mc.mc_lsb_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ld_req = 1'b0; ld_addr = '0; ld_len = '0;
    st_req = 1'b0; st_addr = '0; st_len = '0; st_data = '0;
    mc.mc_if_done = 1'b0; mc.mc_if_data = '0;
    mc.mc_lsb_done = 1'b0; mc.mc_lsb_r_data = '0;

    // reset state
    tick(); tick();
    chk("rst_if_en", mc.mc_if_en, 0);
    chk("rst_lsb_en", mc.mc_lsb_en, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_dones", {if_done, ld_done, st_done}, 0);
    rst = 1'b0;
    tick();

    // single fetch, then back-to-back fetch across the cool cycle
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("f1_en", mc.mc_if_en, 1);
    chk("f1_pc", mc.mc_if_pc, 32'h100);
    chk("f1_lsb_en", mc.mc_lsb_en, 0);
    repeat (5) tick();
    chk("f1_hold", mc.mc_if_en, 1);
    if_cpl(32'h00C0FFEE);
    chk("f1_done", if_done, 1);
    chk("f1_data", if_data, 32'h00C0FFEE);
    chk("f1_en_drop", mc.mc_if_en, 0);
    if_addr = 32'h104;
    tick();
    chk("f1_cool_nogrant", mc.mc_if_en, 0);
    chk("f1_pulse_once", if_done, 0);
    tick();
    chk("f2_en", mc.mc_if_en, 1);
    chk("f2_pc", mc.mc_if_pc, 32'h104);
    if_cpl(32'h11223344);
    chk("f2_data", if_data, 32'h11223344);
    if_req = 1'b0;
    tick();

    // priority ST > LD > IF
    st_req = 1'b1; st_addr = 32'h20; st_data = 32'hAABBCCDD; st_len = 3'd4;
    ld_req = 1'b1; ld_addr = 32'h44; ld_len = 3'd2;
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    chk("p_st_en", mc.mc_lsb_en, 1);
    chk("p_st_rw", mc.mc_lsb_rw, 1);
    chk("p_st_addr", mc.mc_lsb_addr, 32'h20);
    chk("p_st_wdata", mc.mc_lsb_w_data, 32'hAABBCCDD);
    chk("p_st_len", mc.mc_lsb_len, 4);
    chk("p_st_if_en", mc.mc_if_en, 0);
    lsb_cpl(32'hFFFFFFFF);
    chk("p_st_done", st_done, 1);
    chk("p_st_no_ld_done", ld_done, 0);
    chk("p_st_ld_data", ld_data, 0);
    st_req = 1'b0;
    tick();
    chk("p_st_pulse_once", st_done, 0);
    chk("p_cool_lsb_en", mc.mc_lsb_en, 0);
    tick();
    chk("p_ld_en", mc.mc_lsb_en, 1);
    chk("p_ld_rw", mc.mc_lsb_rw, 0);
    chk("p_ld_addr", mc.mc_lsb_addr, 32'h44);
    chk("p_ld_len", mc.mc_lsb_len, 2);
    // stray fetch done while busy with a load is ignored
    mc.mc_if_data = 32'h99999999;
    if_cpl(32'h99999999);
    chk("p_stray_if_done", if_done, 0);
    chk("p_stray_if_data", if_data, 32'h11223344);
    chk("p_stray_ld_en", mc.mc_lsb_en, 1);
    chk("p_stray_ld_done", ld_done, 0);
    lsb_cpl(32'h0000BEEF);
    chk("p_ld_done", ld_done, 1);
    chk("p_ld_data", ld_data, 32'h0000BEEF);
    ld_req = 1'b0;
    tick();
    tick();
    chk("p_if_en", mc.mc_if_en, 1);
    chk("p_if_pc", mc.mc_if_pc, 32'h200);
    if_cpl(32'hCAFEF00D);
    chk("p_if_done", if_done, 1);
    chk("p_if_data", if_data, 32'hCAFEF00D);
    chk("p_ld_data_hold", ld_data, 32'h0000BEEF);
    if_req = 1'b0;
    tick();

    // load squashed by rollback
    ld_req = 1'b1; ld_addr = 32'h40; ld_len = 3'd4;
    tick();
    chk("s_en", mc.mc_lsb_en, 1);
    chk("s_addr", mc.mc_lsb_addr, 32'h40);
    rollback = 1'b1;
    tick();
    rollback = 1'b0; ld_req = 1'b0;
    tick();
    chk("s_en_hold", mc.mc_lsb_en, 1);
    lsb_cpl(32'h12345678);
    chk("s_no_done", ld_done, 0);
    chk("s_data_kept", ld_data, 32'h0000BEEF);
    chk("s_en_drop", mc.mc_lsb_en, 0);
    ld_req = 1'b1; ld_addr = 32'h48;
    tick();
    chk("s_cool", mc.mc_lsb_en, 0);
    tick();
    chk("s_next_en", mc.mc_lsb_en, 1);
    chk("s_next_addr", mc.mc_lsb_addr, 32'h48);
    lsb_cpl(32'h00000055);
    chk("s_next_done", ld_done, 1);
    chk("s_next_data", ld_data, 32'h55);
    ld_req = 1'b0;
    tick();

    // fetch completing in the rollback cycle is squashed
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    chk("r_en", mc.mc_if_en, 1);
    rollback = 1'b1;
    if_cpl(32'hDEAD0000);
    rollback = 1'b0; if_req = 1'b0;
    chk("r_no_done", if_done, 0);
    chk("r_data_kept", if_data, 32'hCAFEF00D);
    chk("r_en_drop", mc.mc_if_en, 0);
    tick();
    if_req = 1'b1; if_addr = 32'h304; rollback = 1'b1;
    tick();
    chk("r_blocked", mc.mc_if_en, 0);
    rollback = 1'b0;
    tick();
    chk("r_after_en", mc.mc_if_en, 1);
    chk("r_after_pc", mc.mc_if_pc, 32'h304);
    if_cpl(32'h0BADC0DE);
    chk("r_after_done", if_done, 1);
    chk("r_after_data", if_data, 32'h0BADC0DE);
    if_req = 1'b0;
    tick();

    // store survives rollback
    st_req = 1'b1; st_addr = 32'h80; st_data = 32'h01020304; st_len = 3'd1;
    tick();
    chk("st_en", mc.mc_lsb_en, 1);
    chk("st_rw", mc.mc_lsb_rw, 1);
    rollback = 1'b1; st_data = 32'hFFFFFFFF;
    tick();
    rollback = 1'b0;
    chk("st_en_hold", mc.mc_lsb_en, 1);
    chk("st_wdata_stable", mc.mc_lsb_w_data, 32'h01020304);
    chk("st_len", mc.mc_lsb_len, 1);
    lsb_cpl(32'h0);
    chk("st_done", st_done, 1);
    st_req = 1'b0;
    tick();

    // stall with rdy=0, completion accepted while stalled
    rdy = 1'b0; if_req = 1'b1; if_addr = 32'h400;
    tick(); tick(); tick();
    chk("stall_no_en", mc.mc_if_en, 0);
    rdy = 1'b1;
    tick();
    chk("stall_en", mc.mc_if_en, 1);
    chk("stall_pc", mc.mc_if_pc, 32'h400);
    rdy = 1'b0;
    tick();
    chk("stall_hold_en", mc.mc_if_en, 1);
    chk("stall_hold_pc", mc.mc_if_pc, 32'h400);
    if_cpl(32'h44444444);
    chk("stall_done", if_done, 1);
    chk("stall_data", if_data, 32'h44444444);
    if_req = 1'b0;
    tick(); tick();

    // asynchronous reset mid fetch
    rdy = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    tick();
    chk("ar_en", mc.mc_if_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_if_en", mc.mc_if_en, 0);
    chk("ar_if_pc", mc.mc_if_pc, 0);
    chk("ar_if_data", if_data, 0);
    chk("ar_ld_data", ld_data, 0);
    tick();
    rst = 1'b0; if_req = 1'b0;
    tick();
    chk("ar_idle", {mc.mc_if_en, mc.mc_lsb_en}, 0);

`ifdef ARB_AGING_EN
    // fetch wins after AGE_LIMIT consecutive load grants
    ld_req = 1'b1; ld_addr = 32'h60; ld_len = 3'd4;
    if_req = 1'b1; if_addr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("age_ld_en", mc.mc_lsb_en, 1);
      chk("age_if_wait", mc.mc_if_en, 0);
      lsb_cpl(i);
      tick();
    end
    tick();
    chk("age_if_en", mc.mc_if_en, 1);
    chk("age_lsb_idle", mc.mc_lsb_en, 0);
    if_cpl(32'h66666666);
    chk("age_if_data", if_data, 32'h66666666);
    if_req = 1'b0; ld_req = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
